plm_bank_array: RTL and testbench

//  Private-local-memory bank array that sits directly downstream of rr_scheduling_kernel.
//  It consumes one PLM input word per kernel slot (NBANKS*NPORTS slots) and performs the

---
 rtl/plm_bank_array.sv | 129 ++++++++++++
 tb/tb_plm_bank_array.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/plm_bank_array.sv
// Private-local-memory bank array fed by the round-robin scheduler: one word per kernel slot per cycle.
// Every bank is zero-filled after reset. After that, each slot writes and reads its bank, and read data comes back one cycle later.
module plm_bank_array #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned NBANKS      = 1,
  parameter int unsigned NPORTS      = 1,
  localparam int unsigned LADDR_WIDTH     = ADDR_WIDTH >> $clog2(NBANKS),
  localparam int unsigned DEPTH           = 2 ** LADDR_WIDTH,
  localparam int unsigned PLM_INPUT_WIDTH = LADDR_WIDTH + VALUE_WIDTH + 1,
  localparam int unsigned NKERNELS        = NBANKS * NPORTS
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NKERNELS-1:0][PLM_INPUT_WIDTH-1:0]  in,
  output logic [NKERNELS-1:0][VALUE_WIDTH-1:0]      rdata,
  output logic                                      init_done,
  output logic [NBANKS-1:0][15:0]                   wr_count
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef struct packed {
    logic                   we;
    logic [LADDR_WIDTH-1:0] laddr;
    logic [VALUE_WIDTH-1:0] wdata;
  } slot_t;

  typedef enum logic {INIT, RUN} state_t;

  slot_t [NKERNELS-1:0]   slots;
  state_t                 state, state_next;
  logic [LADDR_WIDTH-1:0] clr_addr, clr_addr_next;
  logic                   init_done_next;
  logic [CNT_WIDTH:0]     cnt_sum [NBANKS];
  logic [VALUE_WIDTH-1:0] mem [NBANKS][DEPTH];

  assign slots = in;

  // State, clear pointer and init flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clr_addr  <= clr_addr_next;
      init_done <= init_done_next;
    end
  end

  // INIT walks clr_addr across one bank depth and then hands over to RUN
  always_comb begin
    state_next     = state;
    clr_addr_next  = clr_addr;
    init_done_next = init_done;
    case (state)
      INIT: begin
        clr_addr_next = clr_addr + 1'b1;
        if (clr_addr == LADDR_WIDTH'(DEPTH - 1)) begin
          state_next     = RUN;
          init_done_next = 1'b1;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next     = INIT;
        clr_addr_next  = '0;
        init_done_next = 1'b0;
      end
    endcase
  end

  // Storage: zero fill while in INIT. Port writes are applied in port order, so the highest-numbered port wins.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int b = 0; b < NBANKS; b++) begin
        mem[b][clr_addr] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (slots[b*NPORTS+p].we) begin
            mem[b][slots[b*NPORTS+p].laddr] <= slots[b*NPORTS+p].wdata;
          end
        end
      end
    end
  end

  // Read-first registered read: this samples mem before any same-edge write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (state == RUN) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int p = 0; p < NPORTS; p++) begin
          rdata[b*NPORTS+p] <= mem[b][slots[b*NPORTS+p].laddr];
        end
      end
    end else begin
      rdata <= '0;
    end
  end

  // Per-bank tally of this cycle's writes, widened by one bit to detect saturation
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      cnt_sum[b] = {1'b0, wr_count[b]};
      for (int p = 0; p < NPORTS; p++) begin
        cnt_sum[b] = cnt_sum[b] + (CNT_WIDTH + 1)'(slots[b*NPORTS+p].we);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (state == RUN) begin
      for (int b = 0; b < NBANKS; b++) begin
        wr_count[b] <= cnt_sum[b][CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[b][CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_plm_bank_array.sv
// Bench for plm_bank_array with 2 banks x 2 ports and 4 words per bank.
// It applies directed tables and sequences, and runs random traffic against an array-based reference model.
module tb_plm_bank_array;

  localparam int unsigned AW = 4;
  localparam int unsigned VW = 8;
  localparam int unsigned NB = 2;
  localparam int unsigned NP = 2;
  localparam int unsigned LW = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW = LW + VW + 1;
  localparam int unsigned NK = NB * NP;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NK-1:0][PW-1:0]      in = '0;
  logic [NK-1:0][VW-1:0]      rdata;
  logic                       init_done;
  logic [NB-1:0][15:0]        wr_count;

  plm_bank_array #(
    .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NBANKS(NB), .NPORTS(NP)
  ) dut (
    .clk(clk), .reset(reset), .in(in),
    .rdata(rdata), .init_done(init_done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int mem_m [NB][DEPTH];
  int rd_m [NK];
  int cnt_m [NB];
  int init_left;
  bit done_m;

  typedef struct {
    logic [NK-1:0][PW-1:0] w;
    int                    slot;
    logic [VW-1:0]         rd;
    logic [15:0]           wc0;
    logic [15:0]           wc1;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [PW-1:0] wd(input bit we, input int la, input int d);
    return {we, 2'(la), 8'(d)};
  endfunction

  function automatic vec_t mk(input logic [PW-1:0] w0, input logic [PW-1:0] w1,
                              input logic [PW-1:0] w2, input logic [PW-1:0] w3,
                              input int slot, input int rd, input int wc0, input int wc1);
    vec_t v;
    v.w = {w3, w2, w1, w0};
    v.slot = slot;
    v.rd = 8'(rd);
    v.wc0 = 16'(wc0);
    v.wc1 = 16'(wc1);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update for one rising edge: an INIT countdown, then read-first access and sequential port writes
  task automatic model_edge(input logic [NK-1:0][PW-1:0] w);
    if (init_left > 0) begin
      for (int b = 0; b < NB; b++) mem_m[b][DEPTH - init_left] = 0;
      for (int k = 0; k < NK; k++) rd_m[k] = 0;
      init_left--;
      done_m = (init_left == 0);
    end else begin
      for (int k = 0; k < NK; k++) rd_m[k] = mem_m[k / NP][int'(w[k][9:8])];
      for (int k = 0; k < NK; k++) begin
        if (w[k][10]) begin
          mem_m[k / NP][int'(w[k][9:8])] = int'(w[k][7:0]);
          cnt_m[k / NP] = (cnt_m[k / NP] >= 65535) ? 65535 : cnt_m[k / NP] + 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [NK-1:0][VW-1:0] er;
    logic [NB-1:0][15:0]   ec;
    for (int k = 0; k < NK; k++) er[k] = 8'(rd_m[k]);
    for (int b = 0; b < NB; b++) ec[b] = 16'(cnt_m[b]);
    check("model_rdata", 64'(rdata), 64'(er));
    check("model_wr_count", 64'(wr_count), 64'(ec));
    check("model_init_done", 64'(init_done), 64'(done_m));
  endtask

  // Called at a negedge: this drives one cycle of inputs and checks everything at the next negedge
  task automatic step(input logic [NK-1:0][PW-1:0] w);
    in = w;
    @(posedge clk);
    model_edge(w);
    @(negedge clk);
    compare_model();
  endtask

  // Called at a negedge: outputs must clear as soon as reset asserts
  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_left = DEPTH;
    done_m = 1'b0;
    for (int k = 0; k < NK; k++) rd_m[k] = 0;
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;
  endtask

  logic [NK-1:0][PW-1:0] idle;
  logic [NK-1:0][PW-1:0] rw;

  initial begin
    idle = '0;
    for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) mem_m[b][a] = 0;

    tbl[0] = mk(wd(1,2,8'hA5), 0, 0, 0,                       0, 8'h00, 1, 0);
    tbl[1] = mk(0, wd(0,2,0), 0, 0,                           1, 8'hA5, 1, 0);
    tbl[2] = mk(0, 0, wd(1,1,8'h11), wd(1,1,8'h22),           3, 8'h00, 1, 2);
    tbl[3] = mk(0, 0, wd(0,1,0), 0,                           2, 8'h22, 1, 2);
    tbl[4] = mk(wd(1,0,8'h33), wd(0,0,0), 0, 0,               1, 8'h00, 2, 2);
    tbl[5] = mk(0, wd(0,0,0), 0, 0,                           1, 8'h33, 2, 2);
    tbl[6] = mk(wd(1,3,8'h44), wd(1,3,8'h55), 0, 0,           0, 8'h00, 4, 2);
    tbl[7] = mk(wd(0,3,0), 0, 0, 0,                           0, 8'h55, 4, 2);
    tbl[8] = mk(0, 0, wd(0,2,0), wd(1,2,8'h77),               2, 8'h00, 4, 3);
    tbl[9] = mk(wd(0,2,0), 0, 0, 0,                           0, 8'hA5, 4, 3);

    // Power-up reset, then init_done rises on the 4th edge
    @(negedge clk);
    pulse_reset(2);
    for (int i = 1; i <= DEPTH; i++) begin
      step(idle);
      check("init_done_seq", 64'(init_done), 64'(i == DEPTH));
    end
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NK; k++) rw[k] = wd(0, a, 0);
      step(rw);
      check("post_init_zero", 64'(rdata), 64'd0);
    end

    // Writes issued while INIT is running are ignored
    pulse_reset(1);
    step(idle);
    step({wd(1,2,8'hEE), wd(1,2,8'hDD), wd(1,1,8'hCC), wd(1,2,8'hBB)});
    step(idle);
    step(idle);
    step({wd(0,1,0), wd(0,2,0), wd(0,2,0), wd(0,2,0)});
    check("init_write_ignored_rd", 64'(rdata), 64'd0);
    check("init_write_ignored_cnt", 64'(wr_count), 64'd0);

    // Directed table: read-first behaviour, port conflicts and bank isolation
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].w);
      check($sformatf("tbl%0d_rdata", i), 64'(rdata[tbl[i].slot]), 64'(tbl[i].rd));
      check($sformatf("tbl%0d_wc0", i), 64'(wr_count[0]), 64'(tbl[i].wc0));
      check($sformatf("tbl%0d_wc1", i), 64'(wr_count[1]), 64'(tbl[i].wc1));
    end

    // A mid-RUN reset clears counters and re-clears memory
    pulse_reset(1);
    for (int i = 0; i < DEPTH; i++) step(idle);
    check("reinit_done", 64'(init_done), 64'd1);
    step({wd(0,3,0), wd(0,3,0), wd(0,2,0), wd(0,1,0)});
    check("reinit_data_cleared", 64'(rdata), 64'd0);
    check("reinit_cnt_cleared", 64'(wr_count), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NK; k++) rw[k] = wd($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 255));
      step(rw);
    end

    // Saturation: every port writes every cycle until the counters pin at 16'hFFFF
    pulse_reset(1);
    for (int i = 0; i < DEPTH; i++) step(idle);
    for (int i = 0; i < 32800; i++) begin
      for (int k = 0; k < NK; k++) rw[k] = wd(1, $urandom_range(0, 3), $urandom_range(0, 255));
      step(rw);
      if (i == 32766) check("cnt_below_sat", 64'(wr_count[0]), 64'hFFFE);
    end
    check("cnt_saturated0", 64'(wr_count[0]), 64'hFFFF);
    check("cnt_saturated1", 64'(wr_count[1]), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
